// File: rtl/unpu_pkg.sv
// Shared definitions for the LUT activation feeder: lane geometry,
// sequencer state encodings and bundle pipeline offsets.
package unpu_pkg;

    localparam int ACT_WIDTH = 16;
    localparam int LANES     = 4;
    localparam int ACT_DELAY = 1;
    localparam int TABLE_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_CALC  = 3'd2,
        ST_UPD   = 3'd3,
        ST_COMP  = 3'd4
    } state_t;

endpackage

// File: rtl/lut_act_fifo.sv
// Synchronous group FIFO with full/empty flags and a show-ahead head entry.
// Pointers carry one wrap bit so full and empty are distinguishable.
module lut_act_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lut_act_feeder.sv
// Activation sequencer for one LUT bundle: issue, table calc/update,
// then P bit-plane compute cycles with the next issue overlapped on the last.
module lut_act_feeder #(
    parameter int ACT_WIDTH  = unpu_pkg::ACT_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int PLANE_W    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [PLANE_W-1:0]                    cfg_planes,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [unpu_pkg::LANES*ACT_WIDTH-1:0]  in_act,
    input  logic                                  in_mode,
    input  logic                                  in_last,
    output logic                                  new_activation,
    output logic [unpu_pkg::LANES*ACT_WIDTH-1:0]  activations,
    output logic                                  lut_mode,
    output logic                                  comp_valid,
    output logic [PLANE_W-1:0]                    plane_idx,
    output logic                                  tile_done,
    output logic                                  busy
);

    import unpu_pkg::*;

    localparam int GW = LANES * ACT_WIDTH;
    localparam int EW = GW + 2;

    state_t             state;
    logic [PLANE_W-1:0] cnt;
    logic [PLANE_W-1:0] planes;
    logic               last_tag;
    logic [EW-1:0]      head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               final_cycle;

    assign push        = in_valid && !full;
    assign in_ready    = !full;
    assign final_cycle = (state == ST_COMP) &&
                         (cnt == planes - PLANE_W'(1));
    // The next group is popped on the last compute cycle when one is waiting.
    assign pop            = (state == ST_ISSUE) || (final_cycle && !empty);
    assign new_activation = pop;
    assign comp_valid     = (state == ST_COMP);
    assign plane_idx      = comp_valid ? cnt : '0;
    assign tile_done      = final_cycle && last_tag;
    assign busy           = (state != ST_IDLE) || !empty;

    lut_act_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_mode, in_last, in_act}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            planes      <= PLANE_W'(1);
            last_tag    <= 1'b0;
            activations <= '0;
            lut_mode    <= 1'b0;
        end else begin
            if (pop) begin
                activations <= head[GW-1:0];
                last_tag    <= head[GW];
                lut_mode    <= head[GW+1];
                planes      <= (cfg_planes == '0) ? PLANE_W'(1)
                                                  : cfg_planes;
            end
            unique case (state)
                ST_IDLE: begin
                    if (!empty)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: state <= ST_CALC;
                ST_CALC:  state <= ST_UPD;
                ST_UPD: begin
                    cnt   <= '0;
                    state <= ST_COMP;
                end
                ST_COMP: begin
                    if (final_cycle) begin
                        cnt   <= '0;
                        state <= empty ? ST_IDLE : ST_CALC;
                    end else begin
                        cnt <= cnt + PLANE_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_act_feeder.sv
// Directed bench for lut_act_feeder: a cycle table for the single-group
// timing plus a streaming scoreboard for overlap, backpressure and reset.
module tb_lut_act_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cfg_planes;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_act;
    logic        in_mode;
    logic        in_last;
    logic        new_activation;
    logic [63:0] activations;
    logic        lut_mode;
    logic        comp_valid;
    logic [3:0]  plane_idx;
    logic        tile_done;
    logic        busy;

    always #5 clk = ~clk;

    lut_act_feeder #(
        .ACT_WIDTH  (16),
        .FIFO_DEPTH (4),
        .PLANE_W    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_planes     (cfg_planes),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_act         (in_act),
        .in_mode        (in_mode),
        .in_last        (in_last),
        .new_activation (new_activation),
        .activations    (activations),
        .lut_mode       (lut_mode),
        .comp_valid     (comp_valid),
        .plane_idx      (plane_idx),
        .tile_done      (tile_done),
        .busy           (busy)
    );

    typedef struct {
        logic        vld;
        logic [63:0] act;
        logic [3:0]  cfg;
        logic        e_new;
        logic        e_comp;
        logic [3:0]  e_idx;
        logic [63:0] e_act;
        logic        e_busy;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [63:0] g_act  [8];
    logic        g_mode [8];
    logic        g_last [8];

    int   pulse_cyc  [$];
    int   pulse_idx  [$];
    logic pulse_comp [$];
    int   saw_nr;
    int   comps;
    int   dones;
    int   done_idx;
    int   n_iss;
    int   sb_left;
    logic last_mode;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [63:0] act,
                                input logic e_new, input logic e_comp,
                                input logic [3:0] e_idx,
                                input logic [63:0] e_act,
                                input logic e_busy);
        vec_t v;
        v.vld    = vld;
        v.act    = act;
        v.cfg    = 4'd3;
        v.e_new  = e_new;
        v.e_comp = e_comp;
        v.e_idx  = e_idx;
        v.e_act  = e_act;
        v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " new_act"}, 64'(new_activation), 64'd0);
        chk({tag, " acts"}, activations, 64'd0);
        chk({tag, " lut_mode"}, 64'(lut_mode), 64'd0);
        chk({tag, " comp_valid"}, 64'(comp_valid), 64'd0);
        chk({tag, " plane_idx"}, 64'(plane_idx), 64'd0);
        chk({tag, " tile_done"}, 64'(tile_done), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in_valid   = tbl[i].vld;
            in_act     = tbl[i].act;
            in_mode    = 1'b0;
            in_last    = 1'b0;
            cfg_planes = tbl[i].cfg;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d] new_act", tag, i),
                64'(new_activation), 64'(tbl[i].e_new));
            chk($sformatf("%s[%0d] comp_valid", tag, i),
                64'(comp_valid), 64'(tbl[i].e_comp));
            chk($sformatf("%s[%0d] plane_idx", tag, i),
                64'(plane_idx), 64'(tbl[i].e_idx));
            chk($sformatf("%s[%0d] acts", tag, i),
                activations, tbl[i].e_act);
            chk($sformatf("%s[%0d] busy", tag, i),
                64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("%s[%0d] tile_done", tag, i),
                64'(tile_done), 64'd0);
            chk($sformatf("%s[%0d] in_ready", tag, i),
                64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Streams n groups from g_* with an occupancy model and scoreboard.
    task automatic run_groups(input string tag, input int n,
                              input logic [3:0] c0, input logic [3:0] cr,
                              input int budget);
        logic [63:0] sb_act  [$];
        logic        sb_mode [$];
        logic        sb_last [$];
        logic [63:0] exp_act;
        logic        exp_mode;
        logic        cur_last;
        logic        pend;
        logic        fin;
        int          k;
        int          occ;
        int          exp_idx;
        int          pcur;
        int          cyc;
        bit          ended;
        k = 0; occ = 0; exp_idx = 0; pcur = 1; cyc = 0;
        pend = 1'b0; cur_last = 1'b0; ended = 1'b0;
        exp_act = '0; exp_mode = 1'b0;
        pulse_cyc.delete(); pulse_idx.delete(); pulse_comp.delete();
        saw_nr = 0; comps = 0; dones = 0; done_idx = -1; n_iss = 0;
        cfg_planes = c0;
        while (!ended && cyc < budget) begin
            @(negedge clk);
            cyc++;
            chk({tag, " in_ready"}, 64'(in_ready), 64'(occ < 4));
            if (pend) begin
                chk({tag, " acts"}, activations, exp_act);
                chk({tag, " lut_mode"}, 64'(lut_mode), 64'(exp_mode));
                last_mode = exp_mode;
                pend = 1'b0;
                if (n_iss == 1)
                    cfg_planes = cr;
            end
            if (comp_valid) begin
                comps++;
                chk({tag, " plane_idx"}, 64'(plane_idx), 64'(exp_idx));
                fin = (exp_idx == pcur - 1);
                chk({tag, " tile_done"}, 64'(tile_done),
                    64'(fin && cur_last));
                if (tile_done) begin
                    dones++;
                    done_idx = int'(plane_idx);
                end
                exp_idx = fin ? 0 : exp_idx + 1;
            end else begin
                chk({tag, " idle tile_done"}, 64'(tile_done), 64'd0);
            end
            if (new_activation) begin
                pulse_cyc.push_back(cyc);
                pulse_idx.push_back(int'(plane_idx));
                pulse_comp.push_back(comp_valid);
                chk({tag, " mode before load"}, 64'(lut_mode),
                    64'(last_mode));
                if (sb_act.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s issue: got pulse expected empty", tag);
                end else begin
                    exp_act  = sb_act.pop_front();
                    exp_mode = sb_mode.pop_front();
                    cur_last = sb_last.pop_front();
                end
                pcur = (cfg_planes == 4'd0) ? 1 : int'(cfg_planes);
                pend = 1'b1;
                n_iss++;
                occ--;
            end
            if (k < n) begin
                in_valid = 1'b1;
                in_act   = g_act[k];
                in_mode  = g_mode[k];
                in_last  = g_last[k];
                if (in_ready) begin
                    sb_act.push_back(g_act[k]);
                    sb_mode.push_back(g_mode[k]);
                    sb_last.push_back(g_last[k]);
                    k++;
                    occ++;
                end else begin
                    saw_nr = 1;
                end
            end else begin
                in_valid = 1'b0;
            end
            if (k == n && n_iss == n && !pend && !busy)
                ended = 1'b1;
        end
        sb_left = sb_act.size();
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d issues expected %0d",
                     tag, n_iss, n);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        logic [63:0] a1;
        a1 = 64'h0001_0002_0003_0004;

        tbl.push_back(mk(1'b1, a1, 0, 0, 0, 64'd0, 1));
        tbl.push_back(mk(1'b0, '0, 1, 0, 0, 64'd0, 1));
        tbl.push_back(mk(1'b0, '0, 0, 0, 0, a1, 1));
        tbl.push_back(mk(1'b0, '0, 0, 0, 0, a1, 1));
        tbl.push_back(mk(1'b0, '0, 0, 1, 0, a1, 1));
        tbl.push_back(mk(1'b0, '0, 0, 1, 1, a1, 1));
        tbl.push_back(mk(1'b0, '0, 0, 1, 2, a1, 1));
        tbl.push_back(mk(1'b0, '0, 0, 0, 0, a1, 0));
        tbl.push_back(mk(1'b0, '0, 0, 0, 0, a1, 0));

        rst        = 1'b1;
        cfg_planes = 4'd3;
        in_valid   = 1'b0;
        in_act     = '0;
        in_mode    = 1'b0;
        in_last    = 1'b0;
        last_mode  = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        apply_table("t1");

        for (int i = 0; i < 8; i++) begin
            g_act[i]  = {16'(i + 16'h10), 16'(i * 3), 16'hA5A5, 16'(i)};
            g_mode[i] = 1'b0;
            g_last[i] = 1'b0;
        end
        run_groups("t2", 3, 4'd2, 4'd2, 100);
        chk("t2 pulses", 64'(pulse_cyc.size()), 64'd3);
        if (pulse_cyc.size() == 3) begin
            chk("t2 gap1", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd4);
            chk("t2 gap2", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd4);
            chk("t2 idx2", 64'(pulse_idx[1]), 64'd1);
            chk("t2 idx3", 64'(pulse_idx[2]), 64'd1);
            chk("t2 comp2", 64'(pulse_comp[1]), 64'd1);
        end
        chk("t2 ready held", 64'(saw_nr), 64'd0);

        run_groups("t3", 6, 4'd15, 4'd1, 300);
        chk("t3 backpressure", 64'(saw_nr), 64'd1);
        chk("t3 issued", 64'(n_iss), 64'd6);
        chk("t3 sb empty", 64'(sb_left), 64'd0);
        chk("t3 comps", 64'(comps), 64'd20);

        run_groups("t4a", 1, 4'd0, 4'd0, 50);
        chk("t4a comps", 64'(comps), 64'd1);

        g_last[0] = 1'b1;
        run_groups("t4b", 1, 4'd4, 4'd4, 50);
        chk("t4b dones", 64'(dones), 64'd1);
        chk("t4b done idx", 64'(done_idx), 64'd3);
        g_last[0] = 1'b0;

        g_act[0]  = 64'h1111_2222_3333_4444;
        g_act[1]  = 64'h5555_6666_7777_8888;
        g_mode[1] = 1'b1;
        run_groups("t5", 2, 4'd2, 4'd2, 60);
        chk("t5 final mode", 64'(lut_mode), 64'd1);
        chk("t5 final acts", activations, 64'h5555_6666_7777_8888);
        g_mode[1] = 1'b0;

        cfg_planes = 4'd2;
        k = 0;
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(negedge clk);
            if (new_activation)
                seen++;
            if (k < 3) begin
                in_valid = 1'b1;
                in_act   = g_act[k];
                in_mode  = 1'b0;
                in_last  = 1'b0;
                if (in_ready)
                    k++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("t6 second issue", 64'(seen), 64'd2);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("t6 rst");
        @(negedge clk);
        rst       = 1'b0;
        last_mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6 no issue", 64'(new_activation), 64'd0);
            chk("t6 idle", 64'(busy), 64'd0);
        end
        apply_table("t6 rerun");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
